// File: rtl/frame_mem_pkg.sv
// Shared types and helpers for the frame memory responder.
// The client FSM state encoding, address widths and the result-buffer
// address mapping live here so the top and any bench agree on them.
package frame_mem_pkg;

  typedef enum logic [1:0] {LOAD, ARMED, RUN, UNLOAD} state_t;

  localparam int FRAME_AW = 15;
  localparam int RES_AW   = 9;

  // Result word address = set*3 + wr_index, with the multiply done as a
  // shift-and-add so no multiplier is inferred.
  function automatic logic [RES_AW-1:0] res_addr(input logic [7:0] set,
                                                 input logic [1:0] wr_index);
    logic [9:0] w_a;
    w_a = ({2'b00, set} << 1) + {2'b00, set} + {8'b0, wr_index};
    return w_a[RES_AW-1:0];
  endfunction

endpackage

// File: rtl/frame_mem_ram.sv
// Simple dual-port RAM: one synchronous write port, one read port with a
// LAT-cycle (1 or 2) registered read path. The read output registers hold
// their value when no read is issued and clear on reset; the array itself
// is never reset.
module frame_mem_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1024,
  parameter int AW    = 10,
  parameter int LAT   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_q1;

  // Write port.
  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
  end

  // First read stage: capture the addressed word on an issued read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q1 <= '0;
    end else if (re) begin
      r_q1 <= r_mem[raddr];
    end
  end

  generate
    if (LAT == 2) begin : g_lat2
      logic             r_v1;
      logic [WIDTH-1:0] r_q2;
      // Second read stage: forward only words that were actually read.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_v1 <= 1'b0;
          r_q2 <= '0;
        end else begin
          r_v1 <= re;
          if (r_v1) r_q2 <= r_q1;
        end
      end
      assign rdata = r_q2;
    end else begin : g_lat1
      assign rdata = r_q1;
    end
  endgenerate

endmodule

// File: rtl/frame_mem_responder.sv
// Memory-side responder for the NCC frame-processing client.
// Host loads a frame (LOAD), client is released (ARMED), client reads
// pixels and writes results (RUN), host unloads results (UNLOAD).
// Optional build macro FRAME_MEM_STATS_EN adds rd_count/wr_count outputs.
module frame_mem_responder
  import frame_mem_pkg::*;
#(
  parameter int NUM_SETS  = 150,
  parameter int RES_WORDS = 3,
  parameter int RD_LAT    = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        rd_wr,
  input  logic        tem_win,
  input  logic [6:0]  row,
  input  logic [6:0]  col,
  input  logic [31:0] write_data,
  input  logic [7:0]  set,
  input  logic [1:0]  wr_index,
  input  logic        set_done,
  output logic [31:0] read_data,
  output logic        ready_2_start,
  input  logic        host_ld_valid,
  input  logic [14:0] host_ld_addr,
  input  logic [31:0] host_ld_data,
  input  logic        host_ld_last,
  input  logic [8:0]  host_rd_addr,
  output logic [31:0] host_rd_data,
  output logic        frame_ready,
  input  logic        host_ack,
  output logic        err
`ifdef FRAME_MEM_STATS_EN
  ,
  output logic [31:0] rd_count,
  output logic [15:0] wr_count
`endif
);

  localparam int RES_DEPTH = NUM_SETS * RES_WORDS;

  state_t              r_state, w_state_nxt;
  logic                w_rd_accept, w_wr_req, w_wr_legal, w_wr_en;
  logic                w_ld_en, w_err_set, w_host_oor, w_res_re;
  logic                r_host_oor, r_err;
  logic [FRAME_AW-1:0] w_frame_raddr;
  logic [RES_AW-1:0]   w_res_waddr, w_res_raddr;
  logic [31:0]         w_res_rdata;

  assign w_frame_raddr = {tem_win, row, col};
  assign w_wr_legal    = (int'(wr_index) < RES_WORDS) && (int'(set) < NUM_SETS);
  assign w_wr_en       = w_wr_req && w_wr_legal;
  assign w_res_waddr   = res_addr(set, wr_index);
  assign w_host_oor    = int'(host_rd_addr) >= RES_DEPTH;
  assign w_res_raddr   = w_host_oor ? '0 : host_rd_addr;
  assign w_res_re      = (r_state == UNLOAD);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= LOAD;
    else        r_state <= w_state_nxt;
  end

  // Next state, access enables and protocol-error detection.
  always_comb begin
    w_state_nxt = r_state;
    w_rd_accept = 1'b0;
    w_wr_req    = 1'b0;
    w_ld_en     = 1'b0;
    w_err_set   = 1'b0;
    case (r_state)
      LOAD: begin
        w_ld_en = host_ld_valid;
        if (req) w_err_set = 1'b1;
        if (host_ld_valid && host_ld_last) w_state_nxt = ARMED;
      end
      ARMED: begin
        if (host_ld_valid) w_err_set = 1'b1;
        // The releasing read is serviced in the same cycle it is seen.
        if (req && !rd_wr) begin
          w_rd_accept = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (host_ld_valid) w_err_set = 1'b1;
        if (req && !rd_wr) w_rd_accept = 1'b1;
        if (req && rd_wr) begin
          w_wr_req = 1'b1;
          if (!w_wr_legal) w_err_set = 1'b1;
        end
        if (set_done) w_state_nxt = UNLOAD;
      end
      UNLOAD: begin
        if (req || host_ld_valid) w_err_set = 1'b1;
        if (host_ack) w_state_nxt = LOAD;
      end
      default: w_state_nxt = LOAD;
    endcase
  end

  // Sticky error flag and out-of-range tag for the host read return.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err      <= 1'b0;
      r_host_oor <= 1'b0;
    end else begin
      if (w_err_set) r_err <= 1'b1;
      if (w_res_re)  r_host_oor <= w_host_oor;
    end
  end

  assign err           = r_err;
  assign ready_2_start = (r_state == ARMED);
  assign frame_ready   = (r_state == UNLOAD);
  assign host_rd_data  = r_host_oor ? '0 : w_res_rdata;

  frame_mem_ram #(
    .WIDTH(32), .DEPTH(1 << FRAME_AW), .AW(FRAME_AW), .LAT(RD_LAT)
  ) u_frame_ram (
    .clk(clk), .rst_n(rst_n),
    .we(w_ld_en), .waddr(host_ld_addr), .wdata(host_ld_data),
    .re(w_rd_accept), .raddr(w_frame_raddr), .rdata(read_data)
  );

  frame_mem_ram #(
    .WIDTH(32), .DEPTH(RES_DEPTH), .AW(RES_AW), .LAT(1)
  ) u_res_ram (
    .clk(clk), .rst_n(rst_n),
    .we(w_wr_en), .waddr(w_res_waddr), .wdata(write_data),
    .re(w_res_re), .raddr(w_res_raddr), .rdata(w_res_rdata)
  );

`ifdef FRAME_MEM_STATS_EN
  logic [31:0] r_rd_count;
  logic [15:0] r_wr_count;

  // Saturating activity counters, cleared when a new frame is armed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_count <= '0;
      r_wr_count <= '0;
    end else if (r_state == LOAD && w_state_nxt == ARMED) begin
      r_rd_count <= '0;
      r_wr_count <= '0;
    end else begin
      if (w_rd_accept && r_state == RUN && r_rd_count != '1) r_rd_count <= r_rd_count + 1'b1;
      if (w_wr_en && r_wr_count != '1) r_wr_count <= r_wr_count + 1'b1;
    end
  end

  assign rd_count = r_rd_count;
  assign wr_count = r_wr_count;
`endif

endmodule

// File: tb/tb_frame_mem_responder.sv
// Directed bench for frame_mem_responder: load/start, read latency,
// result capture and unload, illegal writes, re-arm, reset mid-RUN.
module tb_frame_mem_responder;

  localparam int RD_LAT = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0, rd_wr = 1'b0, tem_win = 1'b0;
  logic [6:0]  row = '0, col = '0;
  logic [31:0] write_data = '0;
  logic [7:0]  set = '0;
  logic [1:0]  wr_index = '0;
  logic        set_done = 1'b0;
  logic [31:0] read_data;
  logic        ready_2_start;
  logic        host_ld_valid = 1'b0;
  logic [14:0] host_ld_addr = '0;
  logic [31:0] host_ld_data = '0;
  logic        host_ld_last = 1'b0;
  logic [8:0]  host_rd_addr = '0;
  logic [31:0] host_rd_data;
  logic        frame_ready;
  logic        host_ack = 1'b0;
  logic        err;

  int n_chk = 0;
  int n_fail = 0;

  frame_mem_responder #(.NUM_SETS(150), .RES_WORDS(3), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .rd_wr(rd_wr), .tem_win(tem_win),
    .row(row), .col(col), .write_data(write_data), .set(set),
    .wr_index(wr_index), .set_done(set_done), .read_data(read_data),
    .ready_2_start(ready_2_start), .host_ld_valid(host_ld_valid),
    .host_ld_addr(host_ld_addr), .host_ld_data(host_ld_data),
    .host_ld_last(host_ld_last), .host_rd_addr(host_rd_addr),
    .host_rd_data(host_rd_data), .frame_ready(frame_ready),
    .host_ack(host_ack), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = 1'b0; set_done = 1'b0; host_ld_valid = 1'b0; host_ack = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic load_word(input logic tw, input logic [6:0] r, input logic [6:0] c,
                           input logic [31:0] d, input logic last);
    host_ld_valid = 1'b1; host_ld_addr = {tw, r, c}; host_ld_data = d; host_ld_last = last;
    tick();
    host_ld_valid = 1'b0; host_ld_last = 1'b0;
  endtask

  task automatic rd_req(input logic tw, input logic [6:0] r, input logic [6:0] c);
    req = 1'b1; rd_wr = 1'b0; tem_win = tw; row = r; col = c;
    tick();
    req = 1'b0;
  endtask

  task automatic wr_req(input logic [7:0] s, input logic [1:0] idx, input logic [31:0] d);
    req = 1'b1; rd_wr = 1'b1; set = s; wr_index = idx; write_data = d;
    tick();
    req = 1'b0; rd_wr = 1'b0;
  endtask

  task automatic host_read(input logic [8:0] a, output logic [31:0] d);
    host_rd_addr = a;
    tick();
    d = host_rd_data;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    n_chk++; if (read_data !== 32'h0) begin n_fail++; $display("FAIL reset_read_data: got %h want 0", read_data); end
    n_chk++; if (host_rd_data !== 32'h0) begin n_fail++; $display("FAIL reset_host_rd_data: got %h want 0", host_rd_data); end
    do_reset();
    n_chk++; if (ready_2_start !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", ready_2_start); end
    n_chk++; if (frame_ready !== 1'b0) begin n_fail++; $display("FAIL reset_frame_ready: got %b want 0", frame_ready); end
    n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
  endtask

  task automatic test_load_start();
    load_word(1'b0, 7'd0, 7'd0, 32'h1111_1111, 1'b0);
    load_word(1'b1, 7'd5, 7'd9, 32'hDEAD_BEEF, 1'b0);
    load_word(1'b1, 7'd5, 7'd10, 32'hCAFE_0001, 1'b0);
    n_chk++; if (ready_2_start !== 1'b0) begin n_fail++; $display("FAIL load_ready_early: got %b want 0", ready_2_start); end
    load_word(1'b1, 7'd5, 7'd11, 32'hCAFE_0002, 1'b1);
    n_chk++; if (ready_2_start !== 1'b1) begin n_fail++; $display("FAIL load_ready_set: got %b want 1", ready_2_start); end
    rd_req(1'b0, 7'd0, 7'd0);
    n_chk++; if (ready_2_start !== 1'b0) begin n_fail++; $display("FAIL start_ready_drop: got %b want 0", ready_2_start); end
    repeat (RD_LAT - 1) tick();
    n_chk++; if (read_data !== 32'h1111_1111) begin n_fail++; $display("FAIL start_read: got %h want 11111111", read_data); end
    n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL start_err: got %b want 0", err); end
  endtask

  task automatic test_read_latency();
    logic [31:0] exp_q [3];
    exp_q[0] = 32'hDEAD_BEEF; exp_q[1] = 32'hCAFE_0001; exp_q[2] = 32'hCAFE_0002;
    rd_req(1'b1, 7'd5, 7'd9);
    repeat (RD_LAT - 1) tick();
    n_chk++; if (read_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL read_latency: got %h want deadbeef", read_data); end
    // Back-to-back reads of cols 9,10,11 must return in issue order.
    for (int t = 0; t < 3 + RD_LAT; t++) begin
      req = (t < 3); rd_wr = 1'b0; tem_win = 1'b1; row = 7'd5; col = 7'(9 + t);
      tick();
      if (t + 1 >= RD_LAT && t + 1 - RD_LAT < 3) begin
        n_chk++;
        if (read_data !== exp_q[t + 1 - RD_LAT]) begin
          n_fail++; $display("FAIL b2b_read%0d: got %h want %h", t + 1 - RD_LAT, read_data, exp_q[t + 1 - RD_LAT]);
        end
      end
    end
    req = 1'b0;
    repeat (2) tick();
    n_chk++; if (read_data !== 32'hCAFE_0002) begin n_fail++; $display("FAIL read_hold: got %h want cafe0002", read_data); end
  endtask

  task automatic test_result_capture();
    logic [31:0] d;
    wr_req(8'd7, 2'd0, 32'hAAAA_0001);
    wr_req(8'd7, 2'd1, 32'hBBBB_0002);
    wr_req(8'd7, 2'd2, 32'hCCCC_0003);
    wr_req(8'd149, 2'd2, 32'h1490_0002);
    n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL capture_err: got %b want 0", err); end
    // A read coincident with set_done is still serviced.
    req = 1'b1; rd_wr = 1'b0; tem_win = 1'b1; row = 7'd5; col = 7'd9; set_done = 1'b1;
    tick();
    req = 1'b0; set_done = 1'b0;
    n_chk++; if (frame_ready !== 1'b1) begin n_fail++; $display("FAIL capture_frame_ready: got %b want 1", frame_ready); end
    repeat (RD_LAT - 1) tick();
    n_chk++; if (read_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL done_read: got %h want deadbeef", read_data); end
    host_read(9'd21, d);
    n_chk++; if (d !== 32'hAAAA_0001) begin n_fail++; $display("FAIL unload_21: got %h want aaaa0001", d); end
    host_read(9'd22, d);
    n_chk++; if (d !== 32'hBBBB_0002) begin n_fail++; $display("FAIL unload_22: got %h want bbbb0002", d); end
    host_read(9'd23, d);
    n_chk++; if (d !== 32'hCCCC_0003) begin n_fail++; $display("FAIL unload_23: got %h want cccc0003", d); end
    host_read(9'd449, d);
    n_chk++; if (d !== 32'h1490_0002) begin n_fail++; $display("FAIL unload_449: got %h want 14900002", d); end
    host_read(9'd450, d);
    n_chk++; if (d !== 32'h0) begin n_fail++; $display("FAIL unload_oor: got %h want 0", d); end
  endtask

  task automatic test_rearm();
    host_ack = 1'b1;
    tick();
    host_ack = 1'b0;
    n_chk++; if (frame_ready !== 1'b0) begin n_fail++; $display("FAIL rearm_frame_ready: got %b want 0", frame_ready); end
    n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL rearm_err_pre: got %b want 0", err); end
    rd_req(1'b0, 7'd0, 7'd0);
    n_chk++; if (err !== 1'b1) begin n_fail++; $display("FAIL load_req_err: got %b want 1", err); end
    n_chk++; if (ready_2_start !== 1'b0) begin n_fail++; $display("FAIL load_req_ready: got %b want 0", ready_2_start); end
  endtask

  task automatic test_illegal_write();
    logic [31:0] d;
    do_reset();
    load_word(1'b0, 7'd0, 7'd0, 32'h1111_1111, 1'b1);
    rd_req(1'b0, 7'd0, 7'd0);
    wr_req(8'd8, 2'd0, 32'hDDDD_0024);
    n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL illegal_err_pre: got %b want 0", err); end
    // set 7 / index 3 aliases address 24 and must not overwrite it.
    wr_req(8'd7, 2'd3, 32'hEEEE_EEEE);
    n_chk++; if (err !== 1'b1) begin n_fail++; $display("FAIL illegal_idx_err: got %b want 1", err); end
    wr_req(8'd150, 2'd0, 32'hFFFF_FFFF);
    set_done = 1'b1;
    tick();
    set_done = 1'b0;
    host_read(9'd24, d);
    n_chk++; if (d !== 32'hDDDD_0024) begin n_fail++; $display("FAIL illegal_unchanged: got %h want dddd0024", d); end
    host_read(9'd450, d);
    n_chk++; if (d !== 32'h0) begin n_fail++; $display("FAIL illegal_450: got %h want 0", d); end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    load_word(1'b1, 7'd5, 7'd9, 32'hDEAD_BEEF, 1'b1);
    rd_req(1'b1, 7'd5, 7'd9);
    repeat (RD_LAT - 1) tick();
    n_chk++; if (read_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL midrun_read: got %h want deadbeef", read_data); end
    rd_req(1'b1, 7'd5, 7'd10);
    rst_n = 1'b0;
    #2;
    n_chk++; if (read_data !== 32'h0) begin n_fail++; $display("FAIL midrun_rst_data: got %h want 0", read_data); end
    n_chk++; if (ready_2_start !== 1'b0) begin n_fail++; $display("FAIL midrun_rst_ready: got %b want 0", ready_2_start); end
    tick();
    rst_n = 1'b1;
    tick();
    // Back in LOAD: a last-word load arms the client again without error.
    load_word(1'b0, 7'd1, 7'd1, 32'h1234_5678, 1'b1);
    n_chk++; if (ready_2_start !== 1'b1) begin n_fail++; $display("FAIL midrun_reload_ready: got %b want 1", ready_2_start); end
    n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL midrun_reload_err: got %b want 0", err); end
    // Loading outside LOAD is a protocol error.
    load_word(1'b0, 7'd1, 7'd2, 32'h0, 1'b0);
    n_chk++; if (err !== 1'b1) begin n_fail++; $display("FAIL ld_outside_err: got %b want 1", err); end
  endtask

  initial begin
    test_reset();
    test_load_start();
    test_read_latency();
    test_result_capture();
    test_rearm();
    test_illegal_write();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
